// File: rtl/inst_loader.sv
// Byte-stream program loader for the instruction memory load port.
// Optional INST_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module inst_loader #(
   parameter int DEPTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             load_enable,
   output logic [31:0]      write_addr,
   output logic [31:0]      write_data,
   output logic             cpu_reset,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE, S_COUNT, S_DATA, S_WRITE,
      S_DONE, S_ERROR, S_CHECK
   } state_t;

   localparam logic [8:0] DEPTH_B = 9'(DEPTH);

   state_t state_q, state_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [CNT_W-1:0] words_q, words_d;
   logic [1:0] idx_q, idx_d;
   logic [31:0] shreg_q, shreg_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic cpu_rst_q, cpu_rst_d;
`ifdef INST_LOADER_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;
`endif

   logic accept;
   logic restart;
   logic count_bad;
   logic [CNT_W-1:0] words_inc;

   assign accept = byte_valid & byte_ready;
   assign restart = start & (state_q == S_IDLE ||
                             state_q == S_DONE ||
                             state_q == S_ERROR);
   assign count_bad = (byte_data == 8'd0) ||
                      ({1'b0, byte_data} > DEPTH_B);
   assign words_inc = words_q + 1'b1;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR:
            if (start) state_d = S_COUNT;
         S_COUNT:
            if (accept) state_d = count_bad ? S_ERROR : S_DATA;
         S_DATA:
            if (accept && idx_q == 2'd3) state_d = S_WRITE;
         S_WRITE:
            if (words_inc == n_q)
`ifdef INST_LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            else
               state_d = S_DATA;
`ifdef INST_LOADER_CHECKSUM_EN
         S_CHECK:
            if (accept)
               state_d = (byte_data == csum_q) ? S_DONE : S_ERROR;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs decoded from the current state
   always_comb begin
      byte_ready  = 1'b0;
      load_enable = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      error       = 1'b0;
      unique case (state_q)
         S_COUNT: begin byte_ready = 1'b1; busy = 1'b1; end
         S_DATA:  begin byte_ready = 1'b1; busy = 1'b1; end
         S_WRITE: begin load_enable = 1'b1; busy = 1'b1; end
`ifdef INST_LOADER_CHECKSUM_EN
         S_CHECK: begin byte_ready = 1'b1; busy = 1'b1; end
`endif
         S_DONE:  done  = 1'b1;
         S_ERROR: error = 1'b1;
         default: ;
      endcase
   end

   // Datapath: count capture, word assembly, write port registers
   always_comb begin
      n_d       = n_q;
      words_d   = words_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      addr_d    = addr_q;
      data_d    = data_q;
      cpu_rst_d = (state_d != S_DONE);
`ifdef INST_LOADER_CHECKSUM_EN
      csum_d    = csum_q;
      if (accept) csum_d = csum_q ^ byte_data;
      if (restart) csum_d = 8'd0;
`endif
      if (restart) words_d = '0;
      if (state_q == S_COUNT && accept) begin
         n_d   = CNT_W'(byte_data);
         idx_d = 2'd0;
      end
      if (state_q == S_DATA && accept) begin
         shreg_d = {shreg_q[23:0], byte_data};
         idx_d   = idx_q + 2'd1;
         if (idx_q == 2'd3) begin
            data_d = {shreg_q[23:0], byte_data};
            addr_d = {{(30-CNT_W){1'b0}}, words_q, 2'b00};
         end
      end
      if (state_q == S_WRITE) words_d = words_inc;
   end

   // Datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         n_q       <= '0;
         words_q   <= '0;
         idx_q     <= 2'd0;
         shreg_q   <= 32'd0;
         addr_q    <= 32'd0;
         data_q    <= 32'd0;
         cpu_rst_q <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
         csum_q    <= 8'd0;
`endif
      end else begin
         n_q       <= n_d;
         words_q   <= words_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         cpu_rst_q <= cpu_rst_d;
`ifdef INST_LOADER_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign write_addr   = addr_q;
   assign write_data   = data_q;
   assign cpu_reset    = cpu_rst_q;
   assign words_loaded = words_q;

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Sequences program loading into the MIPS instruction memory from a byte stream, such as a UART receiver or a debug host.
- Accepts a word-count byte, then assembles big-endian 32-bit words. Each word is issued as a single-cycle write (load_enable, write_addr, write_data) to the instruction memory's load port.
- Holds the CPU in reset until the whole program has been written.

Parameters:
- DEPTH, 32, number of 32-bit instruction words in the instruction memory (maximum program length).
- CNT_W, 6, width of the word counter; must satisfy 2^CNT_W > DEPTH.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load session.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  incoming stream byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- load_enable  output  1  write strobe to the instruction memory, one cycle per word.
- write_addr  output  32  byte address of the word being written: word index × 4.
- write_data  output  32  assembled instruction word.
- cpu_reset  output  1  active-high hold of the CPU and PC.
- busy  output  1  a load session is in progress.
- done  output  1  program loaded successfully; level, held until the next start.
- error  output  1  load aborted; level, held until the next start.
- words_loaded  output  CNT_W  number of words written in the current session.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - cpu_reset=1.
  - byte_ready, load_enable, busy, done, error = 0.
  - write_addr, write_data, words_loaded = 0.
- Handshake: a byte is accepted on a clock edge where byte_valid=1 and byte_ready=1. byte_ready depends only on state and never on byte_valid.
- IDLE:
  - byte_ready=0; stream bytes are ignored.
  - start=1 → COUNT; words_loaded, done and error cleared; busy=1.
- COUNT (byte_ready=1):
  - The accepted byte is N, the number of words to load.
  - N=0 or N>DEPTH → ERROR.
  - Otherwise store N, clear the byte index → DATA.
- DATA (byte_ready=1):
  - Bytes shift in MSB first: shreg = {shreg[23:0], byte}.
  - When the 4th byte is accepted → WRITE.
- WRITE (byte_ready=0, exactly 1 cycle):
  - load_enable=1, write_data=shreg, write_addr={words_loaded,2'b00}, zero-extended to 32 bits.
  - words_loaded increments at the end of the cycle.
  - If the incremented count equals N → DONE (or CHECK when the optional feature is compiled in); otherwise → DATA.
- Latency: load_enable is high in the cycle immediately after the edge that accepted the 4th byte of a word.
- DONE:
  - busy=0, done=1, cpu_reset=0.
  - Stream bytes are ignored.
  - start=1 → COUNT, which re-asserts cpu_reset the same edge.
- ERROR:
  - busy=0, error=1, cpu_reset=1.
  - start=1 → COUNT.
- cpu_reset = 1 in every state except DONE; registered.
- Outside WRITE: load_enable=0, and write_addr/write_data hold their last values.
- start while busy=1 is ignored; the session is not restarted.
- reset_n asserted mid-session aborts immediately to the reset values. Partially assembled words are discarded and no write is issued.
- A byte_valid pulse while byte_ready=0 is dropped; no buffering.
- Maximum N=DEPTH: addresses run from 0 to (DEPTH-1)×4 with no wrap-around.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE → CHECK (byte_ready=1).
  - A running XOR of all accepted bytes (including the count byte) is compared with the next accepted byte.
  - Match → DONE; mismatch → ERROR.
  - Words already written remain in memory.
- Not defined: there is no CHECK state and the last WRITE goes directly → DONE.

Test Plan:
- Reset and defaults: hold reset_n=0 mid-stream → cpu_reset=1 and all other outputs 0; after release, bytes are ignored until start.
- Basic load:
  - Stimulus: start; bytes 02, 20,01,00,0A, 00,00,00,3F.
  - Expect load_enable pulses at write_addr 0x0 with data 0x2001000A, then at 0x4 with data 0x0000003F.
  - Then done=1, cpu_reset=0, words_loaded=2.
- Bad count:
  - Count byte 00 → error=1, no load_enable, cpu_reset=1.
  - Repeat with count byte 21 (DEPTH=32) → error=1.
- Full depth: N=0x20 with 128 data bytes → 32 writes, last write_addr=0x7C, then done=1.
- Back-pressure and restart:
  - byte_valid held high continuously → byte_ready low in every WRITE cycle and no byte is lost.
  - start during DATA is ignored.
  - start in DONE re-asserts cpu_reset and begins a new session.
- INST_LOADER_CHECKSUM_EN:
  - Bytes 01, 12,34,56,78, then checksum 01^12^34^56^78=0x09 → done=1.
  - Same stream with checksum 0x00 → error=1 and cpu_reset stays 1.
